// File: rtl/rs_pkg.sv
// Shared constants and types for the reservation-station dispatch sequencer.
// Unit indices, RS sizing, flush timing and the controller state encoding.
package rs_pkg;

    localparam int NUM_RS       = 5;
    localparam int RS_DEPTH     = 32;
    // The RS keeps current_block, next_block and out_block permanently reserved.
    localparam int RS_CAP       = RS_DEPTH - 3;
    localparam int OCC_W        = 6;
    localparam int FLUSH_CYCLES = 2;
    localparam int FLUSH_CNT_W  = 2;

    localparam logic [2:0] RS_ALU_IDX = 3'd0;
    localparam logic [2:0] RS_MUL_IDX = 3'd1;
    localparam logic [2:0] RS_DIV_IDX = 3'd2;
    localparam logic [2:0] RS_BR_IDX  = 3'd3;
    localparam logic [2:0] RS_MEM_IDX = 3'd4;

    typedef enum logic {
        CTRL_RUN   = 1'b0,
        CTRL_FLUSH = 1'b1
    } ctrl_state_e;

    function automatic logic unit_legal(input logic [2:0] unit);
        logic legal;
        if (unit < 3'(NUM_RS)) begin
            legal = 1'b1;
        end else begin
            legal = 1'b0;
        end
        return legal;
    endfunction

endpackage

// File: rtl/rs_credit_counter.sv
// Saturating occupancy credit counter for one reservation station.
// Accept (inc) and issue return (dec) in the same cycle cancel out.
module rs_credit_counter
    import rs_pkg::*;
#(
    parameter int CAP = RS_CAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [OCC_W-1:0] occ,
    output logic             full,
    output logic             underflow
);

    localparam logic [OCC_W-1:0] CAP_V = OCC_W'(CAP);

    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_nxt_s;

    // Next occupancy: clear wins, then saturating +1 / -1.
    always_comb begin
        occ_nxt_s = occ_r;
        if (clr) begin
            occ_nxt_s = {OCC_W{1'b0}};
        end else if (inc && !dec) begin
            if (occ_r < CAP_V) begin
                occ_nxt_s = occ_r + 6'd1;
            end else begin
                occ_nxt_s = occ_r;
            end
        end else if (dec && !inc) begin
            if (occ_r != 6'd0) begin
                occ_nxt_s = occ_r - 6'd1;
            end else begin
                occ_nxt_s = occ_r;
            end
        end else begin
            occ_nxt_s = occ_r;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_r <= {OCC_W{1'b0}};
        end else begin
            occ_r <= occ_nxt_s;
        end
    end

    assign occ       = occ_r;
    assign full      = (occ_r >= CAP_V);
    assign underflow = dec && !clr && (occ_r == 6'd0);

endmodule

// File: rtl/rs_dispatch_ctrl.sv
// Dispatch sequencer from rename to the reservation stations: routes accepted
// instructions as one-cycle start pulses, tracks RS credits, drains on flush.
module rs_dispatch_ctrl
    import rs_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dis_valid,
    input  logic [2:0]              dis_unit,
    input  logic [31:0]             dis_inst_num,
    output logic                    dis_ready,
    input  logic [NUM_RS-1:0]       issue_done,
    input  logic                    exception_sig,
    input  logic                    mret_sig,
    output logic [NUM_RS-1:0]       rs_start,
    output logic [31:0]             rs_inst_num,
    output logic [NUM_RS*OCC_W-1:0] rs_occ,
    output logic                    illegal_unit,
    output logic                    credit_err,
    output logic                    ctrl_state
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    ctrl_state_e            state_r;
    ctrl_state_e            state_nxt_s;
    logic [FLUSH_CNT_W-1:0] flush_cnt_r;
    logic [FLUSH_CNT_W-1:0] flush_cnt_nxt_s;

    logic              flush_evt_s;
    logic              run_s;
    logic              unit_full_s;
    logic              ready_s;
    logic              accept_s;
    logic              illegal_s;
    logic [NUM_RS-1:0] inc_s;
    logic [NUM_RS-1:0] dec_s;
    logic [NUM_RS-1:0] full_s;
    logic [NUM_RS-1:0] underflow_s;

    logic [NUM_RS-1:0] rs_start_r;
    logic [31:0]       rs_inst_num_r;
    logic              illegal_r;
    logic              credit_err_r;

    assign flush_evt_s = exception_sig | mret_sig;

    // State and flush down-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= CTRL_RUN;
            flush_cnt_r <= {FLUSH_CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
        end
    end

    // Next state: any flush event (re)loads the counter; FLUSH exits at zero.
    always_comb begin
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        case (state_r)
            CTRL_RUN: begin
                if (flush_evt_s) begin
                    state_nxt_s     = CTRL_FLUSH;
                    flush_cnt_nxt_s = FLUSH_LOAD;
                end else begin
                    state_nxt_s     = CTRL_RUN;
                end
            end
            CTRL_FLUSH: begin
                if (flush_evt_s) begin
                    flush_cnt_nxt_s = FLUSH_LOAD;
                end else if (flush_cnt_r == 2'd0) begin
                    state_nxt_s     = CTRL_RUN;
                end else begin
                    flush_cnt_nxt_s = flush_cnt_r - 2'd1;
                end
            end
            default: begin
                state_nxt_s     = CTRL_RUN;
                flush_cnt_nxt_s = {FLUSH_CNT_W{1'b0}};
            end
        endcase
    end

    // Full flag of the addressed RS; illegal indices read as full.
    always_comb begin
        case (dis_unit)
            RS_ALU_IDX: unit_full_s = full_s[0];
            RS_MUL_IDX: unit_full_s = full_s[1];
            RS_DIV_IDX: unit_full_s = full_s[2];
            RS_BR_IDX:  unit_full_s = full_s[3];
            RS_MEM_IDX: unit_full_s = full_s[4];
            default:    unit_full_s = 1'b1;
        endcase
    end

    // Output decode: flush suppresses accepts, illegal pulses and credit returns.
    always_comb begin
        run_s     = (state_r == CTRL_RUN);
        ready_s   = 1'b0;
        illegal_s = 1'b0;
        inc_s     = {NUM_RS{1'b0}};
        dec_s     = {NUM_RS{1'b0}};
        if (run_s && !flush_evt_s) begin
            ready_s   = unit_legal(dis_unit) && !unit_full_s;
            illegal_s = dis_valid && !unit_legal(dis_unit);
        end else begin
            ready_s   = 1'b0;
            illegal_s = 1'b0;
        end
        accept_s = dis_valid && ready_s;
        for (int k = 0; k < NUM_RS; k++) begin
            inc_s[k] = accept_s && (dis_unit == 3'(k));
            dec_s[k] = issue_done[k] && run_s && !flush_evt_s;
        end
    end

    assign dis_ready = ready_s;

    for (genvar g = 0; g < NUM_RS; g++) begin : g_credit
        rs_credit_counter #(
            .CAP (RS_CAP)
        ) u_credit (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc_s[g]),
            .dec       (dec_s[g]),
            .clr       (flush_evt_s),
            .occ       (rs_occ[g*OCC_W +: OCC_W]),
            .full      (full_s[g]),
            .underflow (underflow_s[g])
        );
    end

    // Registered start pulse, instruction number and error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_start_r    <= {NUM_RS{1'b0}};
            rs_inst_num_r <= 32'd0;
            illegal_r     <= 1'b0;
            credit_err_r  <= 1'b0;
        end else begin
            rs_start_r    <= inc_s;
            illegal_r     <= illegal_s;
            credit_err_r  <= credit_err_r | (|underflow_s);
            if (accept_s) begin
                rs_inst_num_r <= dis_inst_num;
            end else begin
                rs_inst_num_r <= rs_inst_num_r;
            end
        end
    end

    assign rs_start     = rs_start_r;
    assign rs_inst_num  = rs_inst_num_r;
    assign illegal_unit = illegal_r;
    assign credit_err   = credit_err_r;
    assign ctrl_state   = state_r;

endmodule

// File: tb/tb_rs_dispatch_ctrl.sv
// Scoreboard bench for rs_dispatch_ctrl: directed scenarios plus random traffic
// checked against an occupancy/flush-budget reference model.
module tb_rs_dispatch_ctrl;
    import rs_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        dis_valid;
    logic [2:0]  dis_unit;
    logic [31:0] dis_inst_num;
    logic        dis_ready;
    logic [4:0]  issue_done;
    logic        exception_sig;
    logic        mret_sig;
    logic [4:0]  rs_start;
    logic [31:0] rs_inst_num;
    logic [29:0] rs_occ;
    logic        illegal_unit;
    logic        credit_err;
    logic        ctrl_state;

    always #5 clk = ~clk;

    rs_dispatch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .dis_valid     (dis_valid),
        .dis_unit      (dis_unit),
        .dis_inst_num  (dis_inst_num),
        .dis_ready     (dis_ready),
        .issue_done    (issue_done),
        .exception_sig (exception_sig),
        .mret_sig      (mret_sig),
        .rs_start      (rs_start),
        .rs_inst_num   (rs_inst_num),
        .rs_occ        (rs_occ),
        .illegal_unit  (illegal_unit),
        .credit_err    (credit_err),
        .ctrl_state    (ctrl_state)
    );

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;

    typedef struct {
        int          cyc;
        int          kind;     // 0 = dispatch, 1 = illegal unit
        logic [4:0]  onehot;
        logic [31:0] inst;
    } ev_t;
    ev_t exp_q[$];

    // Reference model: credits per RS, remaining FLUSH cycles, sticky error.
    int m_occ[5];
    int m_flush_left;
    bit m_cerr;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic logic [29:0] model_occ();
        logic [29:0] r;
        r = 30'd0;
        for (int k = 0; k < 5; k++) r[6*k +: 6] = 6'(m_occ[k]);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) m_occ[k] = 0;
        m_flush_left = 0;
        m_cerr       = 1'b0;
    endtask

    // Monitor: whenever the DUT presents a start or illegal pulse, pop and compare.
    initial begin
        ev_t ev;
        forever begin
            @(posedge clk);
            #1;
            if (rs_start != 5'd0 || illegal_unit) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {58'd0, rs_start, illegal_unit}, 64'd0);
                end else begin
                    ev = exp_q.pop_front();
                    chk("event_cycle", 64'(cyc_cnt), 64'(ev.cyc));
                    if (ev.kind == 0) begin
                        chk("rs_start", 64'(rs_start), 64'(ev.onehot));
                        chk("rs_inst_num", 64'(rs_inst_num), 64'(ev.inst));
                        chk("illegal_quiet", 64'(illegal_unit), 64'd0);
                    end else begin
                        chk("illegal_unit", 64'(illegal_unit), 64'd1);
                        chk("start_quiet", 64'(rs_start), 64'd0);
                    end
                end
            end
        end
    end

    // One cycle: drive, check dis_ready, advance model, push expected, check state.
    task automatic step(input bit v, input logic [2:0] u, input logic [31:0] inst,
                        input logic [4:0] idn, input bit exc, input bit mr);
        bit  flush;
        bit  run;
        bit  exp_ready;
        bit  acc;
        bit  a;
        bit  d;
        ev_t ev;
        @(negedge clk);
        dis_valid     = v;
        dis_unit      = u;
        dis_inst_num  = inst;
        issue_done    = idn;
        exception_sig = exc;
        mret_sig      = mr;
        #1;
        flush     = exc | mr;
        run       = (m_flush_left == 0);
        exp_ready = 1'b0;
        if (run && !flush && int'(u) < NUM_RS) exp_ready = (m_occ[int'(u)] < RS_CAP);
        chk("dis_ready", 64'(dis_ready), 64'(exp_ready));
        acc = v && exp_ready;
        if (flush) begin
            for (int k = 0; k < 5; k++) m_occ[k] = 0;
            m_flush_left = FLUSH_CYCLES;
        end else if (!run) begin
            m_flush_left--;
        end else begin
            if (acc) begin
                ev.cyc = cyc_cnt + 1; ev.kind = 0; ev.onehot = 5'(1 << u); ev.inst = inst;
                exp_q.push_back(ev);
            end else if (v && int'(u) >= NUM_RS) begin
                ev.cyc = cyc_cnt + 1; ev.kind = 1; ev.onehot = 5'd0; ev.inst = 32'd0;
                exp_q.push_back(ev);
            end
            for (int k = 0; k < 5; k++) begin
                a = acc && (int'(u) == k);
                d = idn[k];
                if (d && m_occ[k] == 0) m_cerr = 1'b1;
                if (a && !d) m_occ[k]++;
                else if (d && !a && m_occ[k] > 0) m_occ[k]--;
            end
        end
        @(posedge clk);
        #1;
        chk("rs_occ", 64'(rs_occ), 64'(model_occ()));
        chk("ctrl_state", 64'(ctrl_state), 64'(m_flush_left > 0));
        chk("credit_err", 64'(credit_err), 64'(m_cerr));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rs_start", 64'(rs_start), 64'd0);
        chk("rst_inst_num", 64'(rs_inst_num), 64'd0);
        chk("rst_rs_occ", 64'(rs_occ), 64'd0);
        chk("rst_illegal", 64'(illegal_unit), 64'd0);
        chk("rst_credit_err", 64'(credit_err), 64'd0);
        chk("rst_ctrl_state", 64'(ctrl_state), 64'd0);
    endtask

    initial begin
        bit          v;
        int          r;
        logic [2:0]  u;
        logic [4:0]  idn;
        bit          exc;
        bit          mr;
        reset = 1'b0;
        dis_valid = 1'b0; dis_unit = 3'd0; dis_inst_num = 32'd0;
        issue_done = 5'd0; exception_sig = 1'b0; mret_sig = 1'b0;
        model_reset();
        #3;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Basic dispatch
        step(1'b1, 3'd0, 32'h10, 5'd0, 1'b0, 1'b0);

        // Fill unit 2, then retry across a credit return
        for (int i = 0; i < RS_CAP; i++) step(1'b1, 3'd2, 32'h200 + 32'(i), 5'd0, 1'b0, 1'b0);
        step(1'b1, 3'd2, 32'h2ff, 5'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'h0, 5'd0, 1'b0, 1'b0);
        step(1'b1, 3'd2, 32'h300, 5'b00100, 1'b0, 1'b0);
        step(1'b1, 3'd2, 32'h301, 5'd0, 1'b0, 1'b0);

        // Simultaneous accept and return on unit 1 at occupancy 4
        for (int i = 0; i < 4; i++) step(1'b1, 3'd1, 32'h400 + 32'(i), 5'd0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'h410, 5'b00010, 1'b0, 1'b0);

        // Flush during an accept with every RS occupied, then mret in 2nd FLUSH cycle
        step(1'b1, 3'd3, 32'h500, 5'd0, 1'b0, 1'b0);
        step(1'b1, 3'd4, 32'h501, 5'd0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'h502, 5'd0, 1'b1, 1'b0);
        step(1'b1, 3'd0, 32'h503, 5'b11111, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'h504, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 32'h510 + 32'(i), 5'd0, 1'b0, 1'b0);

        // Illegal unit and credit underflow
        step(1'b1, 3'd6, 32'h600, 5'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'h0, 5'b01000, 1'b0, 1'b0);
        step(1'b1, 3'd7, 32'h601, 5'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 3'd0, 32'h0, 5'd0, 1'b0, 1'b0);

        // Random traffic: fill-heavy first half, drain-heavy second half
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            u = (r < 8) ? 3'(r) : 3'd2;
            idn = 5'd0;
            for (int k = 0; k < 5; k++)
                idn[k] = (i < 300) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            exc = ($urandom_range(0, 59) == 0);
            mr  = ($urandom_range(0, 99) == 0);
            step(v, u, $urandom, idn, exc, mr);
        end

        // Asynchronous reset while a start pulse is still on the outputs
        step(1'b1, 3'd4, 32'hABCD, 5'd0, 1'b0, 1'b0);
        #2;
        chk("pre_reset_start", 64'(rs_start), 64'(5'b10000));
        reset = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        @(negedge clk);
        dis_valid = 1'b0; issue_done = 5'd0; exception_sig = 1'b0; mret_sig = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 3'd3, 32'h77, 5'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'h0, 5'd0, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
